// File: rtl/rs_alu_sched_pkg.sv
// Shared widths and op-type codes for the ALU reservation station slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
package rs_alu_sched_pkg;

  // Default widths shared with dispatch, ROB and the execute unit
  localparam int RS_DEPTH_DEF = 16;
  localparam int RS_TAG_W     = 4;
  localparam int RS_OP_W      = 6;
  localparam int RS_DATA_W    = 32;

  // Shared op-type encoding (subset used by the ALU/branch path)
  localparam logic [RS_OP_W-1:0] OP_ADD  = 6'h01;
  localparam logic [RS_OP_W-1:0] OP_SUB  = 6'h02;
  localparam logic [RS_OP_W-1:0] OP_AND  = 6'h03;
  localparam logic [RS_OP_W-1:0] OP_OR   = 6'h04;
  localparam logic [RS_OP_W-1:0] OP_SLL  = 6'h05;
  localparam logic [RS_OP_W-1:0] OP_ADDI = 6'h10;
  localparam logic [RS_OP_W-1:0] OP_SLLI = 6'h11;
  localparam logic [RS_OP_W-1:0] OP_BEQ  = 6'h20;
  localparam logic [RS_OP_W-1:0] OP_BNE  = 6'h21;

endpackage

// File: rtl/rs_pick.sv
// Lowest-index priority encoder: reports whether any bit is set and its index.
// Latency: purely combinational.
// Backpressure: none.
module rs_pick #(
  parameter int N  = 16,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan high to low so the lowest set bit is the last (winning) assignment
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/rs_alu_sched.sv
// Reservation station + single-issue scheduler for the ALU/branch execute unit.
// Latency: dispatch -> ex_* registers two edges min; CDB wakeup -> issue two edges.
// Backpressure: rs_full stalls dispatch; rdy_in low freezes all state.
module rs_alu_sched
  import rs_alu_sched_pkg::*;
#(
  parameter int RS_DEPTH = RS_DEPTH_DEF,
  parameter int TAG_W    = RS_TAG_W,
  parameter int OP_W     = RS_OP_W,
  parameter int DATA_W   = RS_DATA_W
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              issue_valid,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic              issue_qj_pend,
  input  logic              issue_qk_pend,
  input  logic [DATA_W-1:0] issue_imm,
  input  logic [DATA_W-1:0] issue_pc,
  input  logic [TAG_W-1:0]  issue_rob_tag,
  output logic              rs_full,
  input  logic              cdb_alu_valid,
  input  logic [TAG_W-1:0]  cdb_alu_tag,
  input  logic [DATA_W-1:0] cdb_alu_data,
  input  logic              cdb_lsb_valid,
  input  logic [TAG_W-1:0]  cdb_lsb_tag,
  input  logic [DATA_W-1:0] cdb_lsb_data,
  output logic              ex_valid,
  output logic [OP_W-1:0]   ex_op,
  output logic [DATA_W-1:0] ex_rs1,
  output logic [DATA_W-1:0] ex_rs2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc,
  output logic [TAG_W-1:0]  ex_rob_tag
);

  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  typedef struct packed {
    logic              busy;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
    logic              j_pend;
    logic              k_pend;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [TAG_W-1:0]  rob_tag;
  } entry_t;

  entry_t ent      [RS_DEPTH];
  entry_t ent_wake [RS_DEPTH];
  entry_t new_ent;

  logic [RS_DEPTH-1:0] busy_vec;
  logic [RS_DEPTH-1:0] ready_vec;
  logic                rdy_found;
  logic [IDX_W-1:0]    rdy_idx;
  logic                free_found;
  logic [IDX_W-1:0]    free_idx;

  // Resolve pending operands against both CDB ports; the ALU port has priority
  // if both ever carry the same tag.
  function automatic entry_t snoop(
    input entry_t            e,
    input logic              av,
    input logic [TAG_W-1:0]  at,
    input logic [DATA_W-1:0] ad,
    input logic              lv,
    input logic [TAG_W-1:0]  lt,
    input logic [DATA_W-1:0] ld
  );
    entry_t r;
    r = e;
    if (e.j_pend) begin
      if (av && (at == e.qj)) begin
        r.vj     = ad;
        r.j_pend = 1'b0;
      end else if (lv && (lt == e.qj)) begin
        r.vj     = ld;
        r.j_pend = 1'b0;
      end
    end
    if (e.k_pend) begin
      if (av && (at == e.qk)) begin
        r.vk     = ad;
        r.k_pend = 1'b0;
      end else if (lv && (lt == e.qk)) begin
        r.vk     = ld;
        r.k_pend = 1'b0;
      end
    end
    return r;
  endfunction

  // Occupancy and readiness come from registered state only, so a wakeup
  // this cycle makes the entry eligible next cycle.
  always_comb begin
    busy_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      busy_vec[i]  = ent[i].busy;
      ready_vec[i] = ent[i].busy && !ent[i].j_pend && !ent[i].k_pend;
    end
  end

  // Next-state view of every resident entry after CDB snooping
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      ent_wake[i] = snoop(ent[i], cdb_alu_valid, cdb_alu_tag, cdb_alu_data,
                          cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_data);
    end
  end

  // Incoming op, with same-cycle CDB bypass applied before it is written
  always_comb begin
    new_ent         = '0;
    new_ent.busy    = 1'b1;
    new_ent.op      = issue_op;
    new_ent.vj      = issue_vj;
    new_ent.vk      = issue_vk;
    new_ent.qj      = issue_qj;
    new_ent.qk      = issue_qk;
    new_ent.j_pend  = issue_qj_pend;
    new_ent.k_pend  = issue_qk_pend;
    new_ent.imm     = issue_imm;
    new_ent.pc      = issue_pc;
    new_ent.rob_tag = issue_rob_tag;
    new_ent = snoop(new_ent, cdb_alu_valid, cdb_alu_tag, cdb_alu_data,
                    cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_data);
  end

  rs_pick #(.N(RS_DEPTH), .IW(IDX_W)) u_pick_ready (
    .vec   (ready_vec),
    .found (rdy_found),
    .idx   (rdy_idx)
  );

  rs_pick #(.N(RS_DEPTH), .IW(IDX_W)) u_pick_free (
    .vec   (~busy_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  assign rs_full = !free_found;

  // Entry array and issue registers: clear beats everything but reset,
  // rdy_in low holds all state.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent[i] <= '0;
      end
      ex_valid   <= 1'b0;
      ex_op      <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_imm     <= '0;
      ex_pc      <= '0;
      ex_rob_tag <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          ent[i].busy <= 1'b0;
        end
        ex_valid <= 1'b0;
      end else begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (ent[i].busy) begin
            ent[i] <= ent_wake[i];
          end
        end
        if (rdy_found) begin
          ex_valid           <= 1'b1;
          ex_op              <= ent[rdy_idx].op;
          ex_rs1             <= ent[rdy_idx].vj;
          ex_rs2             <= ent[rdy_idx].vk;
          ex_imm             <= ent[rdy_idx].imm;
          ex_pc              <= ent[rdy_idx].pc;
          ex_rob_tag         <= ent[rdy_idx].rob_tag;
          ent[rdy_idx].busy  <= 1'b0;
        end else begin
          ex_valid <= 1'b0;
        end
        // free_idx was not busy at cycle start, so it never collides with
        // the selected entry or with a wakeup write.
        if (issue_valid && free_found) begin
          ent[free_idx] <= new_ent;
        end
      end
    end
  end

endmodule
